// File: rtl/heartbeat_generator.sv
// heartbeat_generator: emits watchdog heartbeats only while the monitored subsystem keeps strobing alive.
// Optional macro HEARTBEAT_GENERATOR_URGENT_BEAT_EN adds wd_warning-triggered urgent beats.
module heartbeat_generator #(
    parameter int unsigned PERIOD_CYCLES = 1000,
    parameter int unsigned STALL_LIMIT   = 4,
    parameter int unsigned COUNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               alive,
    input  logic               force_stop,
`ifdef HEARTBEAT_GENERATOR_URGENT_BEAT_EN
    input  logic               wd_warning,
`endif
    output logic               heartbeat,
    output logic               stalled,
    output logic [COUNT_W-1:0] beat_count,
    output logic [1:0]         state_dbg
);

    localparam int unsigned    PW       = $clog2(PERIOD_CYCLES);
    localparam logic [PW-1:0]  TERM_CNT = PW'(PERIOD_CYCLES - 1);
    localparam logic [8:0]     LIMIT9   = 9'(STALL_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_STALLED = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [PW-1:0]      period_r;
    logic [PW-1:0]      period_s;
    logic [7:0]         miss_r;
    logic [7:0]         miss_s;
    logic               seen_r;
    logic               seen_s;
    logic               hb_r;
    logic               hb_s;
    logic               stalled_r;
    logic               stalled_s;
    logic [COUNT_W-1:0] count_r;
    logic [COUNT_W-1:0] count_s;
    logic               urgent_s;

    // Urgent beat request: watchdog is close to expiry and activity was already seen.
    always_comb begin
`ifdef HEARTBEAT_GENERATOR_URGENT_BEAT_EN
        urgent_s = wd_warning & seen_r;
`else
        urgent_s = 1'b0;
`endif
    end

    // Next-state and next-output logic; force_stop falls through to the hold defaults.
    always_comb begin
        state_s   = state_r;
        period_s  = period_r;
        miss_s    = miss_r;
        seen_s    = seen_r;
        stalled_s = stalled_r;
        hb_s      = 1'b0;
        if (force_stop) begin
            hb_s = 1'b0;
        end else if (!enable) begin
            state_s   = ST_IDLE;
            period_s  = '0;
            miss_s    = 8'd0;
            seen_s    = 1'b0;
            stalled_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s   = ST_RUN;
                    period_s  = '0;
                    miss_s    = 8'd0;
                    seen_s    = 1'b0;
                    stalled_s = 1'b0;
                end
                ST_RUN: begin
                    if (urgent_s) begin
                        hb_s     = 1'b1;
                        period_s = '0;
                        miss_s   = 8'd0;
                        seen_s   = 1'b0;
                    end else if (period_r == TERM_CNT) begin
                        // alive in the terminal cycle still counts for this period
                        period_s = '0;
                        if (seen_r | alive) begin
                            hb_s   = 1'b1;
                            miss_s = 8'd0;
                            seen_s = 1'b0;
                        end else if (({1'b0, miss_r} + 9'd1) < LIMIT9) begin
                            hb_s   = 1'b1;
                            miss_s = miss_r + 8'd1;
                        end else begin
                            state_s   = ST_STALLED;
                            stalled_s = 1'b1;
                        end
                    end else begin
                        period_s = period_r + PW'(1);
                        seen_s   = seen_r | alive;
                    end
                end
                ST_STALLED: begin
                    period_s = '0;
                    if (alive) begin
                        hb_s      = 1'b1;
                        state_s   = ST_RUN;
                        stalled_s = 1'b0;
                        miss_s    = 8'd0;
                        seen_s    = 1'b0;
                    end else begin
                        state_s = ST_STALLED;
                    end
                end
                default: begin
                    state_s   = ST_IDLE;
                    period_s  = '0;
                    miss_s    = 8'd0;
                    seen_s    = 1'b0;
                    stalled_s = 1'b0;
                end
            endcase
        end
        count_s = count_r + COUNT_W'(hb_s);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            period_r  <= '0;
            miss_r    <= 8'd0;
            seen_r    <= 1'b0;
            hb_r      <= 1'b0;
            stalled_r <= 1'b0;
            count_r   <= '0;
        end else begin
            state_r   <= state_s;
            period_r  <= period_s;
            miss_r    <= miss_s;
            seen_r    <= seen_s;
            hb_r      <= hb_s;
            stalled_r <= stalled_s;
            count_r   <= count_s;
        end
    end

    assign heartbeat  = hb_r;
    assign stalled    = stalled_r;
    assign beat_count = count_r;
    assign state_dbg  = state_r;

endmodule

// File: tb/tb_heartbeat_generator.sv
// Scoreboard bench for heartbeat_generator: per-cycle reference model plus directed test-plan points.
module tb_heartbeat_generator;

    localparam int P  = 8;
    localparam int L  = 2;
    localparam int CW = 4;
`ifdef HEARTBEAT_GENERATOR_URGENT_BEAT_EN
    localparam bit URGENT = 1'b1;
`else
    localparam bit URGENT = 1'b0;
`endif

    logic          clk        = 1'b0;
    logic          rst        = 1'b1;
    logic          enable     = 1'b0;
    logic          alive      = 1'b0;
    logic          force_stop = 1'b0;
    logic          wd_warning = 1'b0;
    logic          heartbeat;
    logic          stalled;
    logic [CW-1:0] beat_count;
    logic [1:0]    state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic          hb;
        logic [1:0]    st;
        logic [CW-1:0] cnt;
        bit            d_en;
        logic          d_hb;
        logic [1:0]    d_st;
        logic [CW-1:0] d_cnt;
    } exp_t;

    exp_t sb[$];

    // reference model: mode 0=idle 1=running 2=stalled, phase within period, misses, activity flag
    int m_st   = 0;
    int m_ph   = 0;
    int m_miss = 0;
    int m_cnt  = 0;
    bit m_seen = 1'b0;
    bit m_hb   = 1'b0;

    heartbeat_generator #(
        .PERIOD_CYCLES(P),
        .STALL_LIMIT  (L),
        .COUNT_W      (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .alive     (alive),
        .force_stop(force_stop),
`ifdef HEARTBEAT_GENERATOR_URGENT_BEAT_EN
        .wd_warning(wd_warning),
`endif
        .heartbeat (heartbeat),
        .stalled   (stalled),
        .beat_count(beat_count),
        .state_dbg (state_dbg)
    );

    initial forever #5 clk = ~clk;

    function automatic void model_beat();
        m_hb  = 1'b1;
        m_cnt = (m_cnt + 1) % (1 << CW);
    endfunction

    function automatic void model_step(input logic r, input logic e, input logic a,
                                       input logic f, input logic w);
        if (r) begin
            m_st = 0; m_ph = 0; m_miss = 0; m_seen = 1'b0; m_hb = 1'b0; m_cnt = 0;
        end else if (f) begin
            m_hb = 1'b0;
        end else if (!e) begin
            m_st = 0; m_ph = 0; m_miss = 0; m_seen = 1'b0; m_hb = 1'b0;
        end else begin
            m_hb = 1'b0;
            if (m_st == 0) begin
                m_st = 1; m_ph = 0; m_miss = 0; m_seen = 1'b0;
            end else if (m_st == 2) begin
                m_ph = 0;
                if (a) begin
                    model_beat();
                    m_st = 1; m_miss = 0; m_seen = 1'b0;
                end
            end else if (URGENT && w && m_seen) begin
                model_beat();
                m_ph = 0; m_miss = 0; m_seen = 1'b0;
            end else if (m_ph == P - 1) begin
                m_ph = 0;
                if (m_seen || a) begin
                    model_beat();
                    m_miss = 0; m_seen = 1'b0;
                end else if (m_miss + 1 < L) begin
                    model_beat();
                    m_miss++;
                end else begin
                    m_st = 2;
                end
            end else begin
                m_ph++;
                m_seen = m_seen | a;
            end
        end
    endfunction

    task automatic drive(input logic r, input logic e, input logic a, input logic f, input logic w,
                         input bit d_en, input logic d_hb, input logic [1:0] d_st, input int d_cnt);
        exp_t x;
        @(negedge clk);
        rst = r; enable = e; alive = a; force_stop = f; wd_warning = w;
        model_step(r, e, a, f, w);
        x.hb    = m_hb;
        x.st    = 2'(m_st);
        x.cnt   = CW'(m_cnt);
        x.d_en  = d_en;
        x.d_hb  = d_hb;
        x.d_st  = d_st;
        x.d_cnt = CW'(d_cnt);
        sb.push_back(x);
    endtask

    task automatic cyc(input logic r, input logic e, input logic a, input logic f, input logic w);
        drive(r, e, a, f, w, 1'b0, 1'b0, 2'd0, 0);
    endtask

    // Monitor: one expectation per clock, compared just after the active edge.
    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                n_tests++;
                if (heartbeat !== x.hb || stalled !== (x.st == 2'd2) ||
                    beat_count !== x.cnt || state_dbg !== x.st) begin
                    n_fail++;
                    $display("FAIL model t=%0t: got hb=%0b stalled=%0b cnt=%0d st=%0d, want hb=%0b stalled=%0b cnt=%0d st=%0d",
                             $time, heartbeat, stalled, beat_count, state_dbg,
                             x.hb, (x.st == 2'd2), x.cnt, x.st);
                end
                if (x.d_en) begin
                    n_tests++;
                    if (heartbeat !== x.d_hb || stalled !== (x.d_st == 2'd2) ||
                        beat_count !== x.d_cnt || state_dbg !== x.d_st) begin
                        n_fail++;
                        $display("FAIL directed t=%0t: got hb=%0b stalled=%0b cnt=%0d st=%0d, want hb=%0b stalled=%0b cnt=%0d st=%0d",
                                 $time, heartbeat, stalled, beat_count, state_dbg,
                                 x.d_hb, (x.d_st == 2'd2), x.d_cnt, x.d_st);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        logic en_lvl;
        logic a;
        int   fs_left;
        int   rate;

        // reset held with enable and toggling alive
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, (i % 2) == 1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 0);

        // steady run: beats after edges 8, 16, 24
        for (int e = 0; e <= 25; e++)
            drive(1'b0, 1'b1, (e == 4 || e == 12 || e == 20), 1'b0, 1'b0, 1'b1,
                  (e == 8 || e == 16 || e == 24), 2'd1, int'(e >= 8) + int'(e >= 16) + int'(e >= 24));
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 3);

        // stall: grace beat at 8, stalled from 16, silent for 40+ cycles
        for (int e = 0; e <= 56; e++)
            drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, (e == 8), (e < 16) ? 2'd1 : 2'd2, 3 + int'(e >= 8));

        // recovery beat, normal beat, terminal-cycle-only alive beat, then a grace beat
        for (int e = 57; e <= 82; e++)
            drive(1'b0, 1'b1, (e == 57 || e == 61 || e == 73), 1'b0, 1'b0, 1'b1,
                  (e == 57 || e == 65 || e == 73 || e == 81), 2'd1,
                  4 + int'(e >= 57) + int'(e >= 65) + int'(e >= 73) + int'(e >= 81));

        // enable dropped at counter 5: idle, beat count kept
        for (int e = 83; e <= 86; e++) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 8);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8);

        // force_stop across the terminal count, counter resumes from 5
        for (int k = 0; k <= 23; k++)
            drive(1'b0, 1'b1, (k == 2) || (k == 10), (k >= 6 && k <= 15), 1'b0, 1'b1,
                  (k == 18), 2'd1, 8 + int'(k >= 18));

        // reset at counter 5
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 0);

`ifdef HEARTBEAT_GENERATOR_URGENT_BEAT_EN
        // urgent beat, normal beat 8 later, then warning without activity
        for (int j = 0; j <= 16; j++)
            drive(1'b0, 1'b1, (j == 3), 1'b0, (j == 5 || j == 15), 1'b1,
                  (j == 5 || j == 13), 2'd1, int'(j >= 5) + int'(j >= 13));
`endif

        // randomized traffic with quiet windows, bursts of force_stop, rare resets
        en_lvl  = 1'b1;
        fs_left = 0;
        rate    = 3;
        for (int i = 0; i < 4000; i++) begin
            if ((i % 150) == 0) rate = $urandom_range(0, 2);
            if (fs_left > 0) fs_left--;
            else if ($urandom_range(0, 99) == 0) fs_left = $urandom_range(1, 12);
            if (en_lvl) en_lvl = ($urandom_range(0, 149) != 0);
            else        en_lvl = ($urandom_range(0, 3) == 0);
            case (rate)
                0:       a = 1'b0;
                1:       a = ($urandom_range(0, 2) == 0);
                default: a = ($urandom_range(0, 19) == 0);
            endcase
            cyc(($urandom_range(0, 399) == 0), en_lvl, a, (fs_left > 0), ($urandom_range(0, 7) == 0));
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/heartbeat_generator.md
Name: heartbeat_generator

Overview:
- Transmit end of the watchdog interface: produces the `heartbeat` pulse stream that `watchdog_timer` consumes.
- Beats only while a monitored subsystem (DSP sample pipeline / control parser) keeps strobing `alive`. Within a bounded grace budget, beats continue without activity.
- If the subsystem hangs, beats stop deliberately, so the downstream watchdog times out and recovers the design.

Parameters:
- PERIOD_CYCLES, 1000: clock cycles between heartbeat evaluations; legal range 2..2^24.
- STALL_LIMIT, 4: consecutive activity-free periods before heartbeats stop; legal range 1..255.
- COUNT_W, 16: width of `beat_count`.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  level; 0 holds the block idle with counters cleared.
- alive  input  1  single-cycle activity strobe from the monitored subsystem.
- force_stop  input  1  level; freezes the block and suppresses beats (fault injection).
- heartbeat  output  1  single-cycle registered pulse to the watchdog.
- stalled  output  1  high while in STALLED.
- beat_count  output  COUNT_W  total heartbeats emitted; wraps modulo 2^COUNT_W.
- state_dbg  output  2  IDLE=0, RUN=1, STALLED=2.

Behaviour:
- One clock domain. Reset is synchronous and active-high, and it is the highest priority event.
- Reset values:
  - heartbeat=0, stalled=0, beat_count=0, state_dbg=IDLE.
  - Internal registers: period counter=0, miss counter=0, alive_seen=0.
- Priority each edge: rst, then force_stop, then enable=0, then FSM.
- force_stop=1 holds all registers (counters, FSM, alive_seen) and forces heartbeat=0. The `alive` input is ignored while force_stop=1.
- enable=0 in any state: next state is IDLE; counters and alive_seen are cleared; heartbeat=0; stalled=0. beat_count is kept.
- IDLE:
  - On the first edge with enable=1, go to RUN with period counter=0, miss=0, alive_seen=0.
- RUN:
  - Period counter increments every cycle.
  - alive=1 sets alive_seen.
  - Terminal cycle is period counter == PERIOD_CYCLES-1. On that edge the counter wraps to 0 and the evaluation below is made. alive asserted in the terminal cycle counts toward the current period.
  - Evaluation:
    - If alive_seen: heartbeat=1 next cycle, miss=0, alive_seen cleared.
    - Else if miss+1 < STALL_LIMIT: grace beat, heartbeat=1 next cycle, miss increments.
    - Else: no beat, go to STALLED, stalled=1.
  - Result: with continuous activity, heartbeat goes high on edge PERIOD_CYCLES after entering RUN and then every PERIOD_CYCLES cycles.
- STALLED:
  - heartbeat stays 0; the period counter is held at 0.
  - alive=1 produces heartbeat=1 next cycle (recovery beat), stalled=0, state RUN, period counter=0, miss=0, alive_seen=0.
- Every emitted beat (normal, grace, recovery) increments beat_count by 1 in the same edge that raises heartbeat. Wrap from all-ones to 0 is silent.
- heartbeat is never high for two consecutive cycles.
- STALL_LIMIT=1 disables grace beats: the first empty period stalls.

Optional Feature:
- Macro: HEARTBEAT_GENERATOR_URGENT_BEAT_EN.
- When defined:
  - Adds input wd_warning (1 bit), driven by the watchdog warning output.
  - In RUN, when wd_warning=1 and alive_seen=1, heartbeat=1 next cycle. The period counter restarts at 0, miss=0, alive_seen is cleared, and beat_count increments.
  - An urgent beat in the terminal cycle replaces the normal evaluation; only one beat is emitted.
  - wd_warning is ignored in IDLE and STALLED, and while force_stop=1.
- When undefined: the port is absent and behaviour is exactly as above.

Test Plan:
- All directed tests use PERIOD_CYCLES=8, STALL_LIMIT=2.
- Reset: rst=1 for 3 cycles with enable=1 and alive toggling -> heartbeat=0, stalled=0, beat_count=0, state_dbg=0 throughout.
- Steady run: enable=1 at edge 0, alive pulsed at cycles 3, 11, 19 -> heartbeat high exactly at edges 8, 16, 24; beat_count=3; stalled=0.
- Stall:
  - enable=1, alive never asserted -> grace beat at edge 8 (beat_count=1).
  - No beat at edge 16; stalled=1 and state_dbg=2 from edge 16.
  - No heartbeat during the next 40 cycles.
- Recovery and boundary:
  - From STALLED, alive pulse at edge 30 -> heartbeat=1 after edge 31, stalled=0, next beat at edge 39 if alive is seen.
  - alive only in the terminal cycle (counter=7) -> that period still beats.
- Mid-operation control:
  - rst at counter=5 -> all outputs at reset values next edge.
  - enable=0 at counter=5 -> IDLE, beat_count kept.
  - force_stop for 10 cycles spanning a terminal count -> no heartbeat; counter resumes from its frozen value afterwards.
- With HEARTBEAT_GENERATOR_URGENT_BEAT_EN defined:
  - alive at cycle 2 and wd_warning at cycle 4 -> heartbeat after edge 5, counter restarts, next normal beat 8 cycles later.
  - wd_warning with alive_seen=0 -> no beat.
